conv_window_sequencer: RTL
==========================

Name: conv_window_sequencer

Overview:
- Drives the operand select and feature-map read address for the 32-bit input mux that feeds the MAC datapath.
- For each output pixel it emits one bias beat (sel=2'b00, mux passes ip2 = bias word), then K*K tap beats.
- In-bounds taps use sel=2'b01 (mux passes ip1 = feature-map word). Padding taps use sel=2'b10 (mux outputs 32'h0).
- Stride 1, zero padding, one feature-map channel per run.

Parameters:
- IMG_W, 28, input feature-map width in words
- IMG_H, 28, input feature-map height
- K, 3, square kernel size
- PAD, 1, zero-padding border width (0 <= PAD < K)
- ADDR_W, 16, feature-map read address width; IMG_W*IMG_H <= 2**ADDR_W

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle pulse; begins a run when idle
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the final beat is accepted
- valid  out  1  beat valid toward the mux/MAC stage
- ready  in  1  MAC stage accepts the beat when valid&&ready
- sel  out  2  mux select: 00 bias, 01 feature-map word, 10 zero pad
- rd_addr  out  ADDR_W  feature-map address iy*IMG_W+ix; 0 on bias and pad beats
- first  out  1  high on the bias beat of each window
- last  out  1  high on the final tap (ky=kx=K-1) of each window
- out_row  out  clog2(OUT_H)  current output row oy
- out_col  out  clog2(OUT_W)  current output column ox

Behaviour:
- Output size: OUT_W = IMG_W+2*PAD-K+1; OUT_H = IMG_H+2*PAD-K+1.
- Timing: all outputs are registered. The feature-map buffer is asynchronous-read, so ip1 is valid in the same beat as rd_addr.
- Reset values: valid=0, busy=0, done=0, sel=2'b10, rd_addr=0, first=0, last=0, out_row=0, out_col=0; state=IDLE.
- State IDLE: start=1 moves to BIAS on the next edge; oy, ox, ky, kx are zeroed, busy=1, valid=1.
- State BIAS: sel=00, first=1. On accept, go to TAP with ky=kx=0.
- State TAP:
  - Compute iy = oy-PAD+ky and ix = ox-PAD+kx using signed arithmetic one bit wider than the counters.
  - In-bounds (0<=iy<IMG_H and 0<=ix<IMG_W): sel=01, rd_addr=iy*IMG_W+ix. Otherwise sel=10, rd_addr=0.
  - On accept, increment kx. When kx wraps from K-1, kx=0 and ky increments.
  - On accept of the last tap, advance ox. When ox wraps, ox=0 and oy increments; return to BIAS.
  - If the accepted last tap is at oy=OUT_H-1 and ox=OUT_W-1, go to DONE.
- State DONE: valid=0, busy=0, done=1 for exactly one cycle, then IDLE.
- Backpressure: while valid && !ready, every output holds stable. No beat is dropped or duplicated.
- Throughput: one beat per cycle with ready held high; a run takes OUT_W*OUT_H*(K*K+1) beats. The next beat's values are registered on the accepting edge, so there are no bubbles between beats.
- start while busy is ignored.
- start in the same cycle as the DONE pulse is ignored; start is accepted only in IDLE.
- rst has priority over every other input. Mid-run reset aborts immediately: valid=0 next cycle, no done pulse, counters zeroed.

Decomposition:
- Shared package cnn_pkg:
  - select-code constants SEL_BIAS=2'b00, SEL_FMAP=2'b01, SEL_ZERO=2'b10
  - state enumeration
  - OUT_W/OUT_H derivation function
- One natural sub-module: window_counter, the nested oy/ox/ky/kx counter with an advance input and wrap/last flags.
- The sequencer FSM, the bound check and the address multiply stay in the top.

Test Plan:
- Window (0,0), IMG_W=IMG_H=4, K=3, PAD=1, ready=1, start pulse -> beats in order:
  - sel 00
  - 10, 10, 10
  - 10, 01@0, 01@1
  - 10, 01@4, 01@5
  - first=1 only on the bias beat; last=1 only on the 10th beat.
- Interior window (1,1), same config -> tap addresses 0,1,2,4,5,6,8,9,10, all sel=01, out_row=1, out_col=1.
- Last window (3,3), same config:
  - Tap sequence: 01@10, 01@11, 10, 01@14, 01@15, 10, 10, 10, 10.
  - Total valid beats = 160; done pulses once, one cycle after the 160th accept; busy then low.
- Backpressure: hold ready=0 for 5 cycles on beat 7 of window 0 -> sel, rd_addr, first, last and valid are stable throughout; the beat sequence is identical to the ready=1 run.
- Reset at beat 50 -> valid=0 and busy=0 on the next cycle, no done pulse; a fresh start replays from window (0,0).
- start pulsed at beats 3 and 80 during a run -> ignored; exactly 160 beats and one done pulse.

Source files
------------

// File: rtl/cnn_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cnn_pkg: select codes, sequencer states, output-size helpers         |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
package cnn_pkg;

    localparam logic [1:0] SEL_BIAS = 2'b00;
    localparam logic [1:0] SEL_FMAP = 2'b01;
    localparam logic [1:0] SEL_ZERO = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BIAS = 2'd1,
        ST_TAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic int out_dim(input int img, input int k, input int pad);
        return img + 2 * pad - k + 1;
    endfunction

    // A one-value counter still needs a 1-bit port.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/window_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | window_counter: nested oy/ox/ky/kx counter with next-value outputs   |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
module window_counter
    import cnn_pkg::*;
#(
    parameter int OUT_W = 26,
    parameter int OUT_H = 26,
    parameter int K     = 3,
    parameter int ROW_W = cnt_w(OUT_H),
    parameter int COL_W = cnt_w(OUT_W),
    parameter int KW    = cnt_w(K)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [ROW_W-1:0] nxt_oy,
    output logic [COL_W-1:0] nxt_ox,
    output logic [KW-1:0]    nxt_ky,
    output logic [KW-1:0]    nxt_kx,
    output logic             tap_last,
    output logic             win_last
);

    localparam logic [KW-1:0]    c_K_LAST   = KW'(K - 1);
    localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(OUT_W - 1);
    localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(OUT_H - 1);

    logic [ROW_W-1:0] r_oy;
    logic [COL_W-1:0] r_ox;
    logic [KW-1:0]    r_ky;
    logic [KW-1:0]    r_kx;

    assign tap_last = (r_ky == c_K_LAST) && (r_kx == c_K_LAST);
    assign win_last = (r_oy == c_ROW_LAST) && (r_ox == c_COL_LAST);

    // Next values are exported so the sequencer can register its outputs
    // for the coming beat on the same edge the counters move.
    always_comb begin
        nxt_oy = r_oy;
        nxt_ox = r_ox;
        nxt_ky = r_ky;
        nxt_kx = r_kx;
        if (clear) begin
            nxt_oy = '0;
            nxt_ox = '0;
            nxt_ky = '0;
            nxt_kx = '0;
        end else if (advance) begin
            if (r_kx == c_K_LAST) begin
                nxt_kx = '0;
                if (r_ky == c_K_LAST) begin
                    nxt_ky = '0;
                    if (r_ox == c_COL_LAST) begin
                        nxt_ox = '0;
                        nxt_oy = (r_oy == c_ROW_LAST) ? '0 : r_oy + ROW_W'(1);
                    end else begin
                        nxt_ox = r_ox + COL_W'(1);
                    end
                end else begin
                    nxt_ky = r_ky + KW'(1);
                end
            end else begin
                nxt_kx = r_kx + KW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_oy <= '0;
            r_ox <= '0;
            r_ky <= '0;
            r_kx <= '0;
        end else begin
            r_oy <= nxt_oy;
            r_ox <= nxt_ox;
            r_ky <= nxt_ky;
            r_kx <= nxt_kx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_window_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | conv_window_sequencer: bias + KxK tap beats per output pixel, with   |
// | padding detection and feature-map addressing. Revision: 1.0          |
// +--------------------------------------------------------------------+
module conv_window_sequencer
    import cnn_pkg::*;
#(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 3,
    parameter int PAD    = 1,
    parameter int ADDR_W = 16,
    localparam int OUT_W = out_dim(IMG_W, K, PAD),
    localparam int OUT_H = out_dim(IMG_H, K, PAD),
    localparam int ROW_W = cnt_w(OUT_H),
    localparam int COL_W = cnt_w(OUT_W),
    localparam int KW    = cnt_w(K)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              valid,
    input  logic              ready,
    output logic [1:0]        sel,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              first,
    output logic              last,
    output logic [ROW_W-1:0]  out_row,
    output logic [COL_W-1:0]  out_col
);

    localparam logic [KW-1:0] c_K_LAST = KW'(K - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_clear;
    logic             w_advance;
    logic [ROW_W-1:0] w_nxt_oy;
    logic [COL_W-1:0] w_nxt_ox;
    logic [KW-1:0]    w_nxt_ky;
    logic [KW-1:0]    w_nxt_kx;
    logic             w_tap_last;
    logic             w_win_last;
    int               w_iy;
    int               w_ix;
    logic             w_inb;
    logic [1:0]       w_sel_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;

    assign w_accept = valid && ready;

    window_counter #(
        .OUT_W (OUT_W),
        .OUT_H (OUT_H),
        .K     (K),
        .ROW_W (ROW_W),
        .COL_W (COL_W),
        .KW    (KW)
    ) u_window_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_clear),
        .advance  (w_advance),
        .nxt_oy   (w_nxt_oy),
        .nxt_ox   (w_nxt_ox),
        .nxt_ky   (w_nxt_ky),
        .nxt_kx   (w_nxt_kx),
        .tap_last (w_tap_last),
        .win_last (w_win_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_BIAS;
                    w_clear     = 1'b1;
                end
            end
            ST_BIAS: begin
                if (w_accept) begin
                    w_state_nxt = ST_TAP;
                end
            end
            ST_TAP: begin
                if (w_accept) begin
                    w_advance = 1'b1;
                    if (w_tap_last) begin
                        w_state_nxt = w_win_last ? ST_DONE : ST_BIAS;
                    end
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Image coordinates of the upcoming beat; negative or past-edge means pad.
    always_comb begin
        w_iy  = int'(w_nxt_oy) - PAD + int'(w_nxt_ky);
        w_ix  = int'(w_nxt_ox) - PAD + int'(w_nxt_kx);
        w_inb = (w_iy >= 0) && (w_iy < IMG_H) && (w_ix >= 0) && (w_ix < IMG_W);
        w_sel_nxt  = SEL_ZERO;
        w_addr_nxt = '0;
        if (w_state_nxt == ST_BIAS) begin
            w_sel_nxt = SEL_BIAS;
        end else if (w_state_nxt == ST_TAP && w_inb) begin
            w_sel_nxt  = SEL_FMAP;
            w_addr_nxt = ADDR_W'(w_iy * IMG_W + w_ix);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sel     <= SEL_ZERO;
            rd_addr <= '0;
            first   <= 1'b0;
            last    <= 1'b0;
            out_row <= '0;
            out_col <= '0;
        end else begin
            r_state <= w_state_nxt;
            valid   <= (w_state_nxt == ST_BIAS) || (w_state_nxt == ST_TAP);
            busy    <= (w_state_nxt == ST_BIAS) || (w_state_nxt == ST_TAP);
            done    <= (w_state_nxt == ST_DONE);
            sel     <= w_sel_nxt;
            rd_addr <= w_addr_nxt;
            first   <= (w_state_nxt == ST_BIAS);
            last    <= (w_state_nxt == ST_TAP) && (w_nxt_ky == c_K_LAST)
                       && (w_nxt_kx == c_K_LAST);
            out_row <= w_nxt_oy;
            out_col <= w_nxt_ox;
        end
    end

endmodule
`default_nettype wire
